// File: rtl/amem_pkg.sv
// Shared definitions for the A-memory output latch.
// Provides the default data/address widths, the capture source-select
// encoding and the odd-parity helper. The helper is only used when
// AMEM_PARITY_EN is defined.
package amem_pkg;

  localparam int AMEM_WIDTH  = 32;
  localparam int AMEM_ADDR_W = 10;
  // Widest word the parity helper accepts. Narrower words are zero-extended.
  localparam int PAR_MAX_W   = 64;

  // Source of the value captured into `a`, in ascending priority order.
  typedef enum logic [1:0] {
    SEL_RAM = 2'd0,
    SEL_FWD = 2'd1,
    SEL_WR  = 2'd2
  } sel_e;

  // Parity bit that gives the word an odd number of ones.
  function automatic logic odd_par(input logic [PAR_MAX_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/amem_fwd_tracker.sv
// Forward tracker for the pending A-memory read.
// Records any write-back that targets the read address between issue
// and capture. This covers the issue-cycle write, which the RAM returns
// stale because it is read-before-write. It also covers writes that
// arrive while the pipeline is stalled. When several writes hit, the
// last one wins.
module amem_fwd_tracker
  import amem_pkg::*;
#(
  parameter int WIDTH  = AMEM_WIDTH,
  parameter int ADDR_W = AMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              fwd_hit,
  output logic [WIDTH-1:0]  fwd_data
);

  logic issue_hit;
  logic stall_hit;

  assign issue_hit = rd_valid & wr_en & (wr_addr == rd_addr);
  assign stall_hit = p_valid  & wr_en & (wr_addr == p_addr);

  // On an unstalled edge, restart tracking for the read being issued.
  // On a stalled edge, keep accumulating writes to the pending address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (!stall) begin
      fwd_hit <= issue_hit;
      if (issue_hit) fwd_data <= wr_data;
    end else if (stall_hit) begin
      fwd_hit  <= 1'b1;
      fwd_data <= wr_data;
    end
  end

endmodule

// File: rtl/amem_bypass_latch.sv
// Registered A-memory output latch with write-back forwarding.
// A read issued at edge N is captured into `a` at edge N+1 when there is
// no stall. The captured value comes from one of three sources, highest
// priority first:
//   1. a write to the pending address in the capture cycle,
//   2. an earlier forwarded write,
//   3. the RAM data.
// A stall freezes everything except forward tracking.
// Optional feature: define AMEM_PARITY_EN to add the amem_par input and
// the a_parerr output. a_parerr reports an odd-parity error on captures
// that come from the RAM.
module amem_bypass_latch
  import amem_pkg::*;
#(
  parameter int               WIDTH     = AMEM_WIDTH,
  parameter int               ADDR_W    = AMEM_ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  amem,
`ifdef AMEM_PARITY_EN
  input  logic              amem_par,
  output logic              a_parerr,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  a,
  output logic              a_valid,
  output logic              a_bypassed
);

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  logic              wr_hit;
  sel_e              sel;
  logic [WIDTH-1:0]  cap_data;

  amem_fwd_tracker #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .clk      (clk),
    .reset_n  (reset_n),
    .stall    (stall),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .p_valid  (p_valid),
    .p_addr   (p_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  assign wr_hit = wr_en & (wr_addr == p_addr);

  // Pick the capture source. A same-cycle write beats an older forward.
  always_comb begin
    sel      = SEL_RAM;
    cap_data = amem;
    if (wr_hit) begin
      sel      = SEL_WR;
      cap_data = wr_data;
    end else if (fwd_hit) begin
      sel      = SEL_FWD;
      cap_data = fwd_data;
    end
  end

  // Issue and capture registers. All of them hold while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_valid    <= 1'b0;
      p_addr     <= '0;
      a          <= RESET_VAL;
      a_valid    <= 1'b0;
      a_bypassed <= 1'b0;
    end else if (!stall) begin
      p_valid <= rd_valid;
      p_addr  <= rd_addr;
      a_valid <= p_valid;
      if (p_valid) begin
        a          <= cap_data;
        a_bypassed <= (sel != SEL_RAM);
      end
    end
  end

`ifdef AMEM_PARITY_EN
  logic par_bad;

  assign par_bad = (amem_par != odd_par(PAR_MAX_W'(amem)));

  // The parity flag is registered next to `a`. Forwarded data is not checked.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_parerr <= 1'b0;
    end else if (!stall && p_valid) begin
      a_parerr <= (sel == SEL_RAM) & par_bad;
    end
  end
`endif

endmodule
